// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/ack bus between the IF stage and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage with IF/ID register, stall skid buffer and redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCWr,
  input  logic          IFIDWr,
  input  logic          branchTaken,
  input  logic [31:0]   branchTarget,
  input  logic          jump,
  input  logic [31:0]   jumpTarget,
  fetch_stage_if.master imem,
  output logic [31:0]   IFIDInstr,
  output logic [31:0]   IFIDPCPlus4,
  output logic          IFIDValid,
  output logic          fetchBusy
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic        r_pend_vld;
  logic        w_pend_vld_nxt;
  logic [31:0] r_pend_tgt;
  logic [31:0] w_pend_tgt_nxt;
  logic [31:0] r_ifid_instr;
  logic [31:0] w_ifid_instr_nxt;
  logic [31:0] r_ifid_pc4;
  logic [31:0] w_ifid_pc4_nxt;
  logic        r_ifid_vld;
  logic        w_ifid_vld_nxt;

  logic        w_redir;
  logic        w_adv;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_plus4;

  // Unequal PCWr/IFIDWr is treated as a stall, so only both-high advances.
  assign w_redir    = branchTaken | jump;
  assign w_tgt      = branchTaken ? branchTarget : jumpTarget;
  assign w_adv      = PCWr & IFIDWr;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_buf        <= 32'h0;
      r_pend_vld   <= 1'b0;
      r_pend_tgt   <= 32'h0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'h0;
      r_ifid_vld   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_buf        <= w_buf_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_pend_tgt   <= w_pend_tgt_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_vld   <= w_ifid_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_buf_nxt        = r_buf;
    w_pend_vld_nxt   = r_pend_vld;
    w_pend_tgt_nxt   = r_pend_tgt;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_ifid_vld_nxt   = r_ifid_vld;

    case (r_state)
      S_FETCH: begin
        if (imem.imem_ack) begin
          if (w_redir || r_pend_vld) begin
            // Word belongs to the wrong path; jump straight to the new target.
            w_pc_nxt         = w_redir ? w_tgt : r_pend_tgt;
            w_pend_vld_nxt   = 1'b0;
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_vld_nxt   = 1'b0;
          end else if (w_adv) begin
            w_ifid_instr_nxt = imem.imem_rdata;
            w_ifid_pc4_nxt   = w_pc_plus4;
            w_ifid_vld_nxt   = 1'b1;
            w_pc_nxt         = w_pc_plus4;
          end else begin
            w_buf_nxt   = imem.imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else begin
          if (w_redir) begin
            // Address must stay put until ack, so remember where to go next.
            w_pend_vld_nxt   = 1'b1;
            w_pend_tgt_nxt   = w_tgt;
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_vld_nxt   = 1'b0;
          end else if (IFIDWr) begin
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_vld_nxt   = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (w_redir) begin
          w_pc_nxt         = w_tgt;
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_vld_nxt   = 1'b0;
          w_state_nxt      = S_FETCH;
        end else if (w_adv) begin
          w_ifid_instr_nxt = r_buf;
          w_ifid_pc4_nxt   = w_pc_plus4;
          w_ifid_vld_nxt   = 1'b1;
          w_pc_nxt         = w_pc_plus4;
          w_state_nxt      = S_FETCH;
        end
      end
    endcase
  end

  assign imem.imem_req  = (r_state == S_FETCH) && !rst;
  assign imem.imem_addr = r_pc;
  assign fetchBusy      = imem.imem_req && !imem.imem_ack;

  assign IFIDInstr   = r_ifid_instr;
  assign IFIDPCPlus4 = r_ifid_pc4;
  assign IFIDValid   = r_ifid_vld;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with random memory latency and redirects
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWr, IFIDWr, branchTaken, jump;
  logic [31:0] branchTarget, jumpTarget;
  logic [31:0] IFIDInstr, IFIDPCPlus4;
  logic        IFIDValid, fetchBusy;
  logic [31:0] o2_instr, o2_pc4;
  logic        o2_valid, o2_busy;

  always #5 clk = ~clk;

  function automatic logic [31:0] fword(input logic [31:0] a);
    return 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
  endfunction

  fetch_stage_if mem_if();
  fetch_stage_if mem2_if();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PCWr(PCWr), .IFIDWr(IFIDWr),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .imem(mem_if),
    .IFIDInstr(IFIDInstr), .IFIDPCPlus4(IFIDPCPlus4),
    .IFIDValid(IFIDValid), .fetchBusy(fetchBusy)
  );

  // Wrap-around instance: zero-wait memory, never stalled or redirected.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst(rst), .PCWr(1'b1), .IFIDWr(1'b1),
    .branchTaken(1'b0), .branchTarget(32'h0),
    .jump(1'b0), .jumpTarget(32'h0), .imem(mem2_if),
    .IFIDInstr(o2_instr), .IFIDPCPlus4(o2_pc4),
    .IFIDValid(o2_valid), .fetchBusy(o2_busy)
  );

  assign mem2_if.imem_ack   = mem2_if.imem_req;
  assign mem2_if.imem_rdata = fword(mem2_if.imem_addr);

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Expected in-order instruction stream; each redirect/reset opens a new generation.
  typedef struct {
    int          gen;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sbq[$];
  int   gen_issued = 0;

  task automatic push_run(input logic [31:0] start);
    exp_t        e;
    logic [31:0] a;
    gen_issued++;
    a = start;
    for (int i = 0; i < 128; i++) begin
      e.gen   = gen_issued;
      e.instr = fword(a);
      e.pc4   = a + 32'd4;
      sbq.push_back(e);
      a = a + 32'd4;
    end
  endtask

  task automatic set_ctl(input logic adv, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
    PCWr = adv;
    IFIDWr = adv;
    branchTaken = br;
    branchTarget = bt;
    jump = jp;
    jumpTarget = jt;
    if (br || jp) push_run(br ? bt : jt);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acts 2 time units after the edge, after stimulus settles.
  int mem_lat = 0;
  bit mem_rand = 1'b0;
  bit mem_late_ack = 1'b0;
  initial begin
    int cnt;
    int cur_lat;
    cnt = 0;
    cur_lat = 0;
    mem_if.imem_ack = 1'b0;
    mem_if.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        cnt = 0;
        mem_if.imem_ack = mem_late_ack;
        mem_if.imem_rdata = $urandom();
      end else if (mem_if.imem_req) begin
        if (cnt == 0) cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        if (cnt == cur_lat) begin
          mem_if.imem_ack = 1'b1;
          mem_if.imem_rdata = fword(mem_if.imem_addr);
          cnt = 0;
        end else begin
          mem_if.imem_ack = 1'b0;
          mem_if.imem_rdata = $urandom();
          cnt++;
        end
      end else begin
        cnt = 0;
        mem_if.imem_ack = 1'b0;
      end
    end
  end

  // Monitor: judges the results of each edge from the inputs seen the cycle before.
  bit          m_have_prev = 1'b0;
  int          my_gen = 0;
  int          deliveries = 0;
  logic        p_req, p_ack, p_redir, p_adv;
  logic [31:0] p_addr, p_tgt;
  int          p_gen;
  logic [31:0] e_instr, e_pc4;
  logic        e_vld;
  exp_t        ent;

  initial begin
    e_instr = NOP;
    e_pc4 = 32'h0;
    e_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_have_prev = 1'b0;
        my_gen = gen_issued;
        e_instr = NOP;
        e_vld = 1'b0;
        chk1("req_low_in_reset", mem_if.imem_req, 1'b0);
      end else begin
        if (m_have_prev) begin
          if (p_redir) begin
            my_gen = p_gen;
            e_instr = NOP;
            e_vld = 1'b0;
            chk1("flush_valid", IFIDValid, 1'b0);
            chk("flush_instr", IFIDInstr, NOP);
            if (!p_req || p_ack) begin
              chk1("redir_req", mem_if.imem_req, 1'b1);
              chk("redir_addr", mem_if.imem_addr, p_tgt);
            end
          end else if (p_adv) begin
            if (IFIDValid) begin
              while (sbq.size() > 0 && sbq[0].gen < my_gen) void'(sbq.pop_front());
              if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got instr %h, want none queued", IFIDInstr);
              end else begin
                ent = sbq.pop_front();
                chk("sb_instr", IFIDInstr, ent.instr);
                chk("sb_pc4", IFIDPCPlus4, ent.pc4);
                e_instr = ent.instr;
                e_pc4 = ent.pc4;
                e_vld = 1'b1;
                deliveries++;
              end
            end else begin
              chk("bubble_instr", IFIDInstr, NOP);
              e_instr = NOP;
              e_vld = 1'b0;
            end
          end else begin
            chk1("hold_valid", IFIDValid, e_vld);
            chk("hold_instr", IFIDInstr, e_instr);
            if (e_vld) chk("hold_pc4", IFIDPCPlus4, e_pc4);
          end
          if (p_req && !p_ack) begin
            chk1("req_stable", mem_if.imem_req, 1'b1);
            chk("addr_stable", mem_if.imem_addr, p_addr);
          end
        end
        chk1("busy", fetchBusy, mem_if.imem_req && !mem_if.imem_ack);
        p_req = mem_if.imem_req;
        p_ack = mem_if.imem_ack;
        p_addr = mem_if.imem_addr;
        p_redir = branchTaken || jump;
        p_tgt = branchTaken ? branchTarget : jumpTarget;
        p_adv = PCWr && IFIDWr;
        p_gen = gen_issued;
        m_have_prev = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int since;
    logic adv, br, jp;
    logic [31:0] bt, jt;
    int sel;

    rst = 1'b1;
    set_ctl(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    push_run(32'h0);
    repeat (2) cyc();
    @(negedge clk);
    chk1("rst_req", mem_if.imem_req, 1'b0);
    chk1("rst_valid", IFIDValid, 1'b0);
    chk("rst_instr", IFIDInstr, NOP);
    chk("rst_pc4", IFIDPCPlus4, 32'h0);

    cyc(); rst = 1'b0;
    @(negedge clk);
    chk1("first_req", mem_if.imem_req, 1'b1);
    chk("first_addr", mem_if.imem_addr, 32'h0);
    chk("wrap_addr0", mem2_if.imem_addr, 32'hFFFF_FFFC);
    cyc(); @(negedge clk);
    chk("seq_addr4", mem_if.imem_addr, 32'h4);
    chk("seq_instr0", IFIDInstr, 32'h2008_0001);
    chk("seq_pc4_4", IFIDPCPlus4, 32'h4);
    chk1("seq_valid", IFIDValid, 1'b1);
    chk("wrap_addr1", mem2_if.imem_addr, 32'h0);
    chk("wrap_pc4", o2_pc4, 32'h0);
    chk("wrap_instr", o2_instr, fword(32'hFFFF_FFFC));
    cyc(); set_ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("seq_addr8", mem_if.imem_addr, 32'h8);
    chk("seq_instr4", IFIDInstr, 32'h2009_0002);
    chk("seq_pc4_8", IFIDPCPlus4, 32'h8);
    cyc(); @(negedge clk);
    chk1("stall_req", mem_if.imem_req, 1'b0);
    chk("stall_instr", IFIDInstr, 32'h2009_0002);
    cyc(); set_ctl(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk1("release_req", mem_if.imem_req, 1'b0);
    cyc(); mem_lat = 3;
    @(negedge clk);
    chk("release_instr", IFIDInstr, fword(32'h8));
    chk("release_pc4", IFIDPCPlus4, 32'hC);
    chk("release_addr", mem_if.imem_addr, 32'hC);
    chk1("lat_busy0", fetchBusy, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(); @(negedge clk);
      chk1("lat_busy", fetchBusy, 1'b1);
      chk("lat_addr", mem_if.imem_addr, 32'hC);
      chk1("lat_bubble", IFIDValid, 1'b0);
    end
    cyc(); @(negedge clk);
    chk1("lat_ack_busy", fetchBusy, 1'b0);
    chk("lat_ack_addr", mem_if.imem_addr, 32'hC);
    chk1("lat_bubble3", IFIDValid, 1'b0);
    cyc(); @(negedge clk);
    chk("lat_instr", IFIDInstr, fword(32'hC));
    chk("lat_pc4", IFIDPCPlus4, 32'h10);
    chk("br_fetch_addr", mem_if.imem_addr, 32'h10);
    cyc(); set_ctl(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    @(negedge clk);
    chk("br_addr_hold", mem_if.imem_addr, 32'h10);
    cyc(); set_ctl(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("br_addr_hold2", mem_if.imem_addr, 32'h10);
    cyc(); mem_lat = 0;
    @(negedge clk);
    chk1("br_ack", mem_if.imem_ack, 1'b1);
    cyc(); @(negedge clk);
    chk("br_new_addr", mem_if.imem_addr, 32'h40);
    chk1("br_discard_valid", IFIDValid, 1'b0);
    cyc(); @(negedge clk);
    chk("br_instr", IFIDInstr, fword(32'h40));
    cyc(); set_ctl(1'b0, 1'b1, 32'h80, 1'b1, 32'h100);
    @(negedge clk);
    cyc(); set_ctl(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("both_addr", mem_if.imem_addr, 32'h80);
    chk1("both_flush_valid", IFIDValid, 1'b0);
    cyc(); @(negedge clk);
    chk("both_instr", IFIDInstr, fword(32'h80));
    chk("both_pc4", IFIDPCPlus4, 32'h84);

    cyc(); mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (fetchBusy) found = 1'b1;
    end
    chk1("busy_seen", found, 1'b1);
    cyc(); rst = 1'b1; mem_late_ack = 1'b1; push_run(32'h0);
    @(negedge clk);
    chk1("midreq_rst_req", mem_if.imem_req, 1'b0);
    chk1("midreq_rst_busy", fetchBusy, 1'b0);
    cyc(); rst = 1'b0; mem_late_ack = 1'b0; mem_lat = 0;
    @(negedge clk);
    chk("after_rst_addr", mem_if.imem_addr, 32'h0);
    chk1("after_rst_valid", IFIDValid, 1'b0);

    mem_rand = 1'b1;
    since = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      adv = ($urandom_range(0, 3) != 0);
      bt = $urandom() & 32'hFFFF_FFFC;
      jt = $urandom() & 32'hFFFF_FFFC;
      br = 1'b0;
      jp = 1'b0;
      if ($urandom_range(0, 24) == 0 || since >= 100) begin
        sel = int'($urandom_range(0, 2));
        br = (sel != 1);
        jp = (sel != 0);
        since = 0;
      end else begin
        since++;
      end
      set_ctl(adv, br, bt, jp, jt);
    end
    cyc(); set_ctl(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) cyc();
    @(negedge clk);
    total++;
    if (deliveries < 300) begin
      bad++;
      $display("FAIL throughput: got %0d deliveries, want >= 300", deliveries);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Buffers a fetched word when the load-use stall (PCWr/IFIDWr low) blocks it, and applies branch/jump redirects with IF/ID flush.
- Directly upstream of ID; consumes PCWr and IFIDWr from the hazard detection unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted into IF/ID.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCWr  in  1  PC update enable from hazard unit; 0 = stall.
- IFIDWr  in  1  IF/ID write enable from hazard unit; 0 = hold.
- branchTaken  in  1  branch resolved taken; redirect plus flush.
- branchTarget  in  32  branch destination.
- jump  in  1  jump decoded in ID; redirect plus flush.
- jumpTarget  in  32  jump destination.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- IFIDInstr  out  32  instruction to ID.
- IFIDPCPlus4  out  32  fetched PC + 4 to ID.
- IFIDValid  out  1  IF/ID holds a real instruction.
- fetchBusy  out  1  request outstanding (FETCH state with no ack yet).

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, imem_req=0 while rst=1, IFIDInstr=NOP_INSTR, IFIDPCPlus4=0, IFIDValid=0, buffer empty, pending redirect cleared. The first request is issued in the first cycle after rst falls.
- States: FETCH (imem_req=1, imem_addr=pc) and HOLD (imem_req=0, word in skid buffer).
- Handshake: once imem_req is raised, imem_addr stays constant until the cycle imem_ack=1. Zero-wait ack (same cycle as req) is legal. A new request may issue the cycle after an ack.
- Redirect: redir = branchTaken | jump. Target = branchTarget if branchTaken, else jumpTarget; branch wins when both are set.
- Redirect forces IF/ID to bubble (NOP_INSTR, valid=0), overriding IFIDWr=0.
- FETCH, ack=1, no redirect, no pending redirect:
  - PCWr&IFIDWr: IF/ID <= {imem_rdata, pc+4}, valid=1, pc <= pc+4, stay in FETCH.
  - Otherwise: buffer <= imem_rdata, go to HOLD, pc unchanged, IF/ID held.
- FETCH, ack=0:
  - If IFIDWr=1: IF/ID <= bubble.
  - If a redirect is present: latch target into pending register, keep the address stable, pc unchanged.
- FETCH, ack=1 with redirect or pending redirect: discard imem_rdata. pc <= current redirect target if present, else pending target. Clear pending; IF/ID bubble.
- HOLD:
  - PCWr&IFIDWr: IF/ID <= {buffer, pc+4}, valid=1, pc <= pc+4, go to FETCH.
  - Redirect: drop buffer, pc <= target, IF/ID bubble, go to FETCH.
  - Otherwise: hold everything.
- Latency: one cycle from ack to IFIDInstr; one cycle from redirect to the new imem_addr (or on ack if a request is outstanding).
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. Targets are used unmodified; low two bits are not checked.
- PCWr≠IFIDWr (illegal from the hazard unit): treated as a stall; no state advances.
- Reset asserted mid-request: the request is abandoned, and any late ack after reset while req=0 is ignored.

Test Plan:
- Reset, zero-wait memory returning 0x20080001, 0x20090002, … -> imem_addr 0,4,8 on consecutive cycles; IFIDInstr trails by one cycle with IFIDPCPlus4 4,8,12 and valid=1.
- Stall: PCWr=IFIDWr=0 for 2 cycles at pc=8, ack=1 -> HOLD with imem_req=0, IF/ID unchanged. On release, IFIDInstr = word@8, next imem_addr=12.
- 3-cycle memory latency, IFIDWr=1 -> fetchBusy=1 and IF/ID bubbles (valid=0, instr=0) for 3 cycles, then the real word arrives; imem_addr stays stable throughout.
- branchTaken=1, target 0x40, during outstanding fetch at 0x10 with ack 2 cycles later -> data from 0x10 discarded, next imem_addr=0x40, IFIDValid=0.
- branchTaken and jump together (0x80 vs 0x100) while IFIDWr=0 -> pc=0x80 and IF/ID flushed despite the stall.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 0; IFIDPCPlus4=0 for the first instruction.
